array_controller_param: RTL and testbench
=========================================

Name: array_controller_param

Overview:
Parametrised next-generation systolic-array controller. Decodes AHB control-register commands and sequences SRAM-buffer reads for weight load, input streaming, skew drain and output write-back. Sits between the AHB control register/SRAM buffer and a ROWS x ROWS systolic array. Adds generic array size, abort, per-wait watchdog timeout and a sticky error state over the fixed 8x8 controller.

Parameters:
ROWS, 8, array dimension; rows loaded and lanes per data word
ELEM_W, 8, bits per array element; data width = ROWS*ELEM_W
CNT_W, 7, width of num_inputs and the input-vector counter
TMO_W, 8, width of the watchdog counter and timeout_cfg

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
ctrl_reg  in  8  bit0 start inference, bit1 load weights, bit2 abort, bit3 clear error; others reserved
num_inputs  in  CNT_W  input vectors per inference; sampled at start
timeout_cfg  in  TMO_W  max wait cycles per SRAM request; 0 disables watchdog
data_ready  in  1  SRAM buffer: data valid, one-cycle pulse
out_done  in  1  SRAM buffer: output write-back complete, one-cycle pulse
data  in  ROWS*ELEM_W  SRAM read data
busy  out  1  operation in progress
inference_done  out  1  one-cycle pulse at inference end
error  out  1  sticky timeout flag
get_weights  out  1  one-cycle weight-row request
get_inputs  out  1  one-cycle input-vector request
get_out  out  1  one-cycle output write-back request
in_valid  out  1  array_inputs holds an input vector this cycle
array_inputs  out  ROWS*ELEM_W  registered data to array
load  out  ROWS  one-hot weight-row load strobe

Behaviour:
- Reset: state IDLE; all outputs 0; row/input/drain/timer counters 0; ctrl_reg history 0.
- Commands act on the rising edge of ctrl_reg bits: ctrl_reg & ~prev, with prev registered every cycle. Bits 0/1 are accepted only in IDLE. FSM leaves IDLE on the clock edge that samples the rise, so the first request strobe appears one cycle after that edge.
- If bit0 and bit1 rise together, weight load wins and start is dropped. Start with num_inputs==0 is ignored.
- States: IDLE, GET_W, WAIT_W, SEND_W, GET_I, WAIT_I, SEND_I, DRAIN, GET_OUT, WAIT_OUT, DONE, ERR.
- Weight load, for row r = 0..ROWS-1:
  - GET_W asserts get_weights for one cycle, then WAIT_W.
  - In WAIT_W, data_ready captures data into array_inputs, then SEND_W.
  - SEND_W drives load = 1<<r for one cycle with array_inputs stable. r increments.
  - After row ROWS-1: IDLE.
- Inference, for k = 0..num_inputs-1:
  - GET_I / WAIT_I behave the same as the weight states.
  - SEND_I asserts in_valid for one cycle.
  - After the last vector: DRAIN for exactly 2*ROWS-1 cycles with in_valid=0 and array_inputs=0.
  - GET_OUT asserts get_out for one cycle.
  - WAIT_OUT waits for out_done, then DONE.
  - DONE asserts inference_done for one cycle, then IDLE.
- busy=1 in every state except IDLE and ERR, including DONE.
- data_ready or out_done outside the matching WAIT state is ignored.
- Watchdog:
  - Timer clears on entry to any WAIT state and increments each WAIT cycle.
  - When timer == timeout_cfg != 0 without the awaited pulse, go to ERR; error=1.
  - If the pulse and the expiry land in the same cycle, the pulse wins.
  - ERR holds, with all strobes 0, until bit3 rises; then error=0 and IDLE.
- Abort (bit2 rise) in any state except IDLE/ERR:
  - Next cycle: IDLE, strobes 0, counters 0, array_inputs 0.
  - No inference_done; weights already loaded are not undone.
- rst mid-operation: identical to reset values on the next cycle.
- Counters are unsigned. Drain count fits clog2(2*ROWS) bits, and no counter wraps within one operation.

Decomposition:
- Package array_ctrl_pkg: state enum; ctrl_reg bit index constants (CMD_START=0, CMD_LOADW=1, CMD_ABORT=2, CMD_CLRERR=3); drain-length function 2*ROWS-1.
- Sub-module ctrl_wait_timer: clear/enable/expire watchdog counter of width TMO_W.
- The FSM, edge detect and datapath registers stay in the top module.

Test Plan:
1. ROWS=8, bit1 rise, data_ready 8 cycles after each get_weights, data=row index -> load 0x01,0x02,...,0x80, each one cycle after its data_ready; busy drops after the last row.
2. num_inputs=3, bit0 rise -> 3 get_inputs/in_valid pairs; 15 drain cycles; get_out; out_done -> inference_done pulse exactly once; busy=0 next cycle.
3. timeout_cfg=5, no data_ready after get_weights -> error=1 five cycles into WAIT_W; busy=0; bit3 rise -> error=0, IDLE. Repeat with data_ready in cycle 5 -> no error.
4. Abort in DRAIN and in WAIT_I -> IDLE next cycle, no inference_done; a fresh weight load then completes normally.
5. Bits 0 and 1 rise together -> weight load only. Bit0 rise while busy -> ignored. num_inputs=0 -> stays IDLE.
6. ROWS=4, ELEM_W=16 -> load is 4 bits wide, drain lasts 7 cycles; rst asserted mid-load clears all outputs on the next cycle.

Source files
------------

// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the parametrised systolic-array controller:
// FSM state encoding, ctrl_reg command bit positions and the drain length.
package array_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_W, S_WAIT_W, S_SEND_W,
    S_GET_I, S_WAIT_I, S_SEND_I, S_DRAIN,
    S_GET_OUT, S_WAIT_OUT, S_DONE, S_ERR
  } state_t;

  localparam int CMD_START  = 0;
  localparam int CMD_LOADW  = 1;
  localparam int CMD_ABORT  = 2;
  localparam int CMD_CLRERR = 3;

  // Cycles needed for the last input to skew through a rows x rows array.
  function automatic int drain_len(input int rows);
    return 2 * rows - 1;
  endfunction

endpackage

// File: rtl/array_controller_param_timer.sv
// Watchdog for a single SRAM wait.
//   clk, rst : clock, synchronous active-high reset
//   clear    : hold count at zero (asserted whenever not waiting)
//   enable   : a wait cycle is in progress
//   limit    : wait-cycle budget, 0 disables expiry
//   expire   : this is wait cycle number `limit` (combinational)
module ctrl_wait_timer #(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] count;
  logic [TMO_W:0]   cycle_no;

  // count holds completed wait cycles, so the current cycle is count+1.
  assign cycle_no = {1'b0, count} + {{TMO_W{1'b0}}, 1'b1};
  assign expire   = enable && (limit != '0) && (cycle_no == {1'b0, limit});

  always_ff @(posedge clk) begin
    if (rst || clear)          count <= '0;
    else if (enable && !expire) count <= count + TMO_W'(1);
  end

endmodule

// File: rtl/array_controller_param.sv
// Systolic-array controller: decodes ctrl_reg command edges and sequences
// SRAM reads for weight load, input streaming, skew drain and write-back.
//   clk, rst        : clock, synchronous active-high reset
//   ctrl_reg        : b0 start, b1 load weights, b2 abort, b3 clear error
//   num_inputs      : vectors per inference, sampled at start
//   timeout_cfg     : per-request wait budget, 0 disables the watchdog
//   data_ready/data : SRAM read response
//   out_done        : SRAM write-back complete
//   busy, inference_done, error                 : status
//   get_weights, get_inputs, get_out            : SRAM request strobes
//   in_valid, array_inputs, load                : array datapath
// All outputs are registered and valid during the state they belong to.
module array_controller_param
  import array_ctrl_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int ELEM_W = 8,
  parameter int CNT_W  = 7,
  parameter int TMO_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             ctrl_reg,
  input  logic [CNT_W-1:0]       num_inputs,
  input  logic [TMO_W-1:0]       timeout_cfg,
  input  logic                   data_ready,
  input  logic                   out_done,
  input  logic [ROWS*ELEM_W-1:0] data,
  output logic                   busy,
  output logic                   inference_done,
  output logic                   error,
  output logic                   get_weights,
  output logic                   get_inputs,
  output logic                   get_out,
  output logic                   in_valid,
  output logic [ROWS*ELEM_W-1:0] array_inputs,
  output logic [ROWS-1:0]        load
);

  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DR_W       = $clog2(2 * ROWS);
  localparam int DRAIN_LAST = drain_len(ROWS) - 1;

  state_t           state;
  logic [3:0]       prev;
  logic [3:0]       rise;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] vec;
  logic [CNT_W-1:0] n_vec;
  logic [DR_W-1:0]  drain;
  logic             waiting;
  logic             expire;
  logic             abort_hit;
  logic             unused_rsvd;

  assign unused_rsvd = ^ctrl_reg[7:4];
  assign rise        = ctrl_reg[3:0] & ~prev;
  assign waiting     = (state == S_WAIT_W) || (state == S_WAIT_I) || (state == S_WAIT_OUT);
  assign abort_hit   = rise[CMD_ABORT] && (state != S_IDLE) && (state != S_ERR);

  ctrl_wait_timer #(.TMO_W(TMO_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waiting),
    .enable (waiting),
    .limit  (timeout_cfg),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      prev           <= '0;
      row            <= '0;
      vec            <= '0;
      n_vec          <= '0;
      drain          <= '0;
      busy           <= 1'b0;
      inference_done <= 1'b0;
      error          <= 1'b0;
      get_weights    <= 1'b0;
      get_inputs     <= 1'b0;
      get_out        <= 1'b0;
      in_valid       <= 1'b0;
      array_inputs   <= '0;
      load           <= '0;
    end else begin
      prev           <= ctrl_reg[3:0];
      // Strobes are single-cycle; only the branch that enters their state re-arms them.
      get_weights    <= 1'b0;
      get_inputs     <= 1'b0;
      get_out        <= 1'b0;
      in_valid       <= 1'b0;
      load           <= '0;
      inference_done <= 1'b0;

      if (abort_hit) begin
        state        <= S_IDLE;
        busy         <= 1'b0;
        row          <= '0;
        vec          <= '0;
        drain        <= '0;
        array_inputs <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            // Weight load takes priority when both commands rise together.
            if (rise[CMD_LOADW]) begin
              state       <= S_GET_W;
              get_weights <= 1'b1;
              busy        <= 1'b1;
              row         <= '0;
            end else if (rise[CMD_START] && (num_inputs != '0)) begin
              state      <= S_GET_I;
              get_inputs <= 1'b1;
              busy       <= 1'b1;
              n_vec      <= num_inputs;
              vec        <= '0;
            end
          end
          S_GET_W: state <= S_WAIT_W;
          S_WAIT_W: begin
            // A response in the expiry cycle still counts.
            if (data_ready) begin
              array_inputs <= data;
              load         <= ROWS'(1) << row;
              state        <= S_SEND_W;
            end else if (expire) begin
              state <= S_ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_SEND_W: begin
            if (row == ROW_W'(ROWS - 1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              row   <= '0;
            end else begin
              row         <= row + ROW_W'(1);
              state       <= S_GET_W;
              get_weights <= 1'b1;
            end
          end
          S_GET_I: state <= S_WAIT_I;
          S_WAIT_I: begin
            if (data_ready) begin
              array_inputs <= data;
              in_valid     <= 1'b1;
              state        <= S_SEND_I;
            end else if (expire) begin
              state <= S_ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_SEND_I: begin
            if (vec == n_vec - CNT_W'(1)) begin
              vec          <= '0;
              drain        <= '0;
              array_inputs <= '0;
              state        <= S_DRAIN;
            end else begin
              vec        <= vec + CNT_W'(1);
              state      <= S_GET_I;
              get_inputs <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (drain == DR_W'(DRAIN_LAST)) begin
              drain   <= '0;
              state   <= S_GET_OUT;
              get_out <= 1'b1;
            end else begin
              drain <= drain + DR_W'(1);
            end
          end
          S_GET_OUT: state <= S_WAIT_OUT;
          S_WAIT_OUT: begin
            if (out_done) begin
              state          <= S_DONE;
              inference_done <= 1'b1;
            end else if (expire) begin
              state <= S_ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          S_ERR: begin
            if (rise[CMD_CLRERR]) begin
              error <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_array_controller_param.sv
module tb_array_controller_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // ROWS=8, ELEM_W=8 instance
  logic        rst, data_ready, out_done;
  logic [7:0]  ctrl_reg;
  logic [6:0]  num_inputs;
  logic [7:0]  timeout_cfg;
  logic [63:0] data;
  logic        busy, inference_done, error, get_weights, get_inputs, get_out, in_valid;
  logic [63:0] array_inputs;
  logic [7:0]  load;

  // ROWS=4, ELEM_W=16 instance
  logic        rst4, dr4, od4;
  logic [7:0]  ctrl4;
  logic [6:0]  num4;
  logic [7:0]  tmo4;
  logic [63:0] data4;
  logic        busy4, infd4, err4, gw4, gi4, go4, iv4;
  logic [63:0] ai4;
  logic [3:0]  load4;

  int checks = 0;
  int errors = 0;

  array_controller_param #(.ROWS(8), .ELEM_W(8), .CNT_W(7), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .ctrl_reg(ctrl_reg), .num_inputs(num_inputs),
    .timeout_cfg(timeout_cfg), .data_ready(data_ready), .out_done(out_done),
    .data(data), .busy(busy), .inference_done(inference_done), .error(error),
    .get_weights(get_weights), .get_inputs(get_inputs), .get_out(get_out),
    .in_valid(in_valid), .array_inputs(array_inputs), .load(load)
  );

  array_controller_param #(.ROWS(4), .ELEM_W(16), .CNT_W(7), .TMO_W(8)) dut4 (
    .clk(clk), .rst(rst4), .ctrl_reg(ctrl4), .num_inputs(num4),
    .timeout_cfg(tmo4), .data_ready(dr4), .out_done(od4),
    .data(data4), .busy(busy4), .inference_done(infd4), .error(err4),
    .get_weights(gw4), .get_inputs(gi4), .get_out(go4),
    .in_valid(iv4), .array_inputs(ai4), .load(load4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a prompt data_ready one cycle after each get_weights until busy drops.
  // Call while the DUT is in GET_W or SEND_W.
  task automatic run_weights(output int nload, output logic [7:0] loads_or, output int ngi);
    logic pgw = 1'b0;
    nload = 0; loads_or = '0; ngi = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      data_ready = pgw;
      data = 64'(c);
      pgw = get_weights;
      tick;
      if (load != 0) begin nload++; loads_or |= load; end
      if (get_inputs) ngi++;
    end
    data_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst4 = 1'b1;
    tick; tick;
    checks++;
    if ({busy, inference_done, error, get_weights, get_inputs, get_out, in_valid} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000",
        {busy, inference_done, error, get_weights, get_inputs, get_out, in_valid});
    end
    checks++;
    if (load !== 8'h00 || array_inputs !== 64'h0) begin
      errors++; $display("FAIL reset_data: got load=%h ai=%h expected 0", load, array_inputs);
    end
    rst = 1'b0; rst4 = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_weight_load;
    ctrl_reg = 8'h02;
    tick;
    checks++;
    if (get_weights !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL wl_start: gw=%b busy=%b expected 1 1", get_weights, busy);
    end
    ctrl_reg = 8'h00;
    for (int r = 0; r < 8; r++) begin
      tick;
      checks++;
      if (get_weights !== 1'b0) begin errors++; $display("FAIL wl_gw_pulse: gw=%b expected 0", get_weights); end
      repeat (7) tick;
      data_ready = 1'b1; data = 64'(r);
      tick;
      checks++;
      if (load !== (8'h01 << r) || array_inputs !== 64'(r)) begin
        errors++; $display("FAIL wl_load row %0d: load=%h ai=%h expected %h %h", r, load, array_inputs, 8'h01 << r, r);
      end
      data_ready = 1'b0;
      tick;
      checks++;
      if (r < 7) begin
        if (get_weights !== 1'b1 || load !== 8'h00) begin
          errors++; $display("FAIL wl_next row %0d: gw=%b load=%h expected 1 00", r, get_weights, load);
        end
      end else begin
        if (busy !== 1'b0 || get_weights !== 1'b0) begin
          errors++; $display("FAIL wl_end: busy=%b gw=%b expected 0 0", busy, get_weights);
        end
      end
    end
  endtask

  task automatic test_inference;
    int n;
    num_inputs = 7'd3;
    ctrl_reg = 8'h01;
    tick;
    checks++;
    if (get_inputs !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL inf_start: gi=%b busy=%b expected 1 1", get_inputs, busy);
    end
    ctrl_reg = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick; tick;
      data_ready = 1'b1; data = 64'hA5A5_0000_0000_00A0 + 64'(k);
      tick;
      checks++;
      if (in_valid !== 1'b1 || array_inputs !== (64'hA5A5_0000_0000_00A0 + 64'(k))) begin
        errors++; $display("FAIL inf_send %0d: iv=%b ai=%h", k, in_valid, array_inputs);
      end
      data_ready = 1'b0;
      tick;
      checks++;
      if (k < 2) begin
        if (get_inputs !== 1'b1 || in_valid !== 1'b0) begin
          errors++; $display("FAIL inf_next %0d: gi=%b iv=%b expected 1 0", k, get_inputs, in_valid);
        end
      end else begin
        if (in_valid !== 1'b0 || array_inputs !== 64'h0 || get_inputs !== 1'b0) begin
          errors++; $display("FAIL inf_drain_entry: iv=%b ai=%h gi=%b expected 0 0 0", in_valid, array_inputs, get_inputs);
        end
      end
    end
    n = 1;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (get_out) break;
      n++;
    end
    checks++;
    if (n !== 15 || get_out !== 1'b1) begin
      errors++; $display("FAIL inf_drain_len: got %0d cycles go=%b expected 15 1", n, get_out);
    end
    tick; tick; tick;
    checks++;
    if (inference_done !== 1'b0) begin errors++; $display("FAIL inf_early_done: got %b expected 0", inference_done); end
    out_done = 1'b1;
    tick;
    checks++;
    if (inference_done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL inf_done: done=%b busy=%b expected 1 1", inference_done, busy);
    end
    out_done = 1'b0;
    tick;
    checks++;
    if (inference_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL inf_idle: done=%b busy=%b expected 0 0", inference_done, busy);
    end
  endtask

  task automatic test_watchdog;
    timeout_cfg = 8'd5;
    ctrl_reg = 8'h02;
    tick;
    ctrl_reg = 8'h00;
    repeat (5) tick;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wd_cycle5: err=%b busy=%b expected 0 1", error, busy);
    end
    tick;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL wd_expire: err=%b busy=%b expected 1 0", error, busy);
    end
    ctrl_reg = 8'h02;
    tick; tick;
    checks++;
    if (error !== 1'b1 || get_weights !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wd_err_hold: err=%b gw=%b busy=%b expected 1 0 0", error, get_weights, busy);
    end
    ctrl_reg = 8'h08;
    tick;
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL wd_clear: err=%b expected 0", error); end
    ctrl_reg = 8'h00;
    tick;
    checks++;
    if (busy !== 1'b0 || get_weights !== 1'b0) begin
      errors++; $display("FAIL wd_idle: busy=%b gw=%b expected 0 0", busy, get_weights);
    end
    // Response lands in the expiry cycle: must be accepted.
    ctrl_reg = 8'h02;
    tick;
    ctrl_reg = 8'h00;
    repeat (5) tick;
    data_ready = 1'b1; data = 64'h77;
    tick;
    checks++;
    if (error !== 1'b0 || load !== 8'h01) begin
      errors++; $display("FAIL wd_race: err=%b load=%h expected 0 01", error, load);
    end
    data_ready = 1'b0;
    ctrl_reg = 8'h04;
    tick;
    checks++;
    if (busy !== 1'b0 || load !== 8'h00 || array_inputs !== 64'h0) begin
      errors++; $display("FAIL wd_abort: busy=%b load=%h ai=%h expected 0 00 0", busy, load, array_inputs);
    end
    ctrl_reg = 8'h00;
    timeout_cfg = 8'd0;
    tick;
  endtask

  task automatic test_abort;
    int ndone;
    int nload, ngi;
    logic [7:0] lor;
    // Abort during DRAIN
    num_inputs = 7'd1;
    ctrl_reg = 8'h01;
    tick;
    ctrl_reg = 8'h00;
    tick;
    data_ready = 1'b1; data = 64'h1234;
    tick;
    data_ready = 1'b0;
    tick; tick;
    ctrl_reg = 8'h04;
    tick;
    checks++;
    if (busy !== 1'b0 || in_valid !== 1'b0 || array_inputs !== 64'h0) begin
      errors++; $display("FAIL ab_drain: busy=%b iv=%b ai=%h expected 0 0 0", busy, in_valid, array_inputs);
    end
    ctrl_reg = 8'h00;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      tick;
      if (inference_done || get_out) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL ab_drain_done: got %0d done/get_out cycles expected 0", ndone); end
    // Abort during WAIT_I
    num_inputs = 7'd2;
    ctrl_reg = 8'h01;
    tick;
    ctrl_reg = 8'h00;
    tick; tick;
    ctrl_reg = 8'h04;
    tick;
    checks++;
    if (busy !== 1'b0 || get_inputs !== 1'b0) begin
      errors++; $display("FAIL ab_wait_i: busy=%b gi=%b expected 0 0", busy, get_inputs);
    end
    ctrl_reg = 8'h00;
    data_ready = 1'b1;
    tick;
    checks++;
    if (in_valid !== 1'b0 || load !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL ab_stray_ready: iv=%b load=%h busy=%b expected 0 00 0", in_valid, load, busy);
    end
    data_ready = 1'b0;
    // Fresh weight load after abort
    ctrl_reg = 8'h02;
    tick;
    ctrl_reg = 8'h00;
    run_weights(nload, lor, ngi);
    checks++;
    if (nload !== 8 || lor !== 8'hFF || busy !== 1'b0) begin
      errors++; $display("FAIL ab_reload: loads=%0d or=%h busy=%b expected 8 ff 0", nload, lor, busy);
    end
  endtask

  task automatic test_commands;
    int nload, ngi, extra;
    logic [7:0] lor;
    // Both bits rise together: weight load only
    num_inputs = 7'd2;
    ctrl_reg = 8'h03;
    tick;
    checks++;
    if (get_weights !== 1'b1 || get_inputs !== 1'b0) begin
      errors++; $display("FAIL cmd_both: gw=%b gi=%b expected 1 0", get_weights, get_inputs);
    end
    ctrl_reg = 8'h00;
    run_weights(nload, lor, ngi);
    extra = 0;
    for (int c = 0; c < 5; c++) begin tick; if (get_inputs || busy) extra++; end
    checks++;
    if (nload !== 8 || ngi !== 0 || extra !== 0) begin
      errors++; $display("FAIL cmd_both_seq: loads=%0d gi=%0d extra=%0d expected 8 0 0", nload, ngi, extra);
    end
    // Start rising during a weight load is ignored
    ctrl_reg = 8'h02;
    tick;
    ctrl_reg = 8'h00;
    tick;
    ctrl_reg = 8'h01;
    tick;
    ctrl_reg = 8'h00;
    data_ready = 1'b1; data = 64'h5;
    tick;
    data_ready = 1'b0;
    checks++;
    if (load !== 8'h01) begin errors++; $display("FAIL cmd_busy_load: load=%h expected 01", load); end
    run_weights(nload, lor, ngi);
    extra = 0;
    for (int c = 0; c < 5; c++) begin tick; if (get_inputs || busy) extra++; end
    checks++;
    if (nload !== 7 || lor !== 8'hFE || ngi !== 0 || extra !== 0) begin
      errors++; $display("FAIL cmd_busy_start: loads=%0d or=%h gi=%0d extra=%0d expected 7 fe 0 0", nload, lor, ngi, extra);
    end
    // Start with zero vectors is ignored
    num_inputs = 7'd0;
    ctrl_reg = 8'h01;
    tick;
    checks++;
    if (busy !== 1'b0 || get_inputs !== 1'b0) begin
      errors++; $display("FAIL cmd_zero: busy=%b gi=%b expected 0 0", busy, get_inputs);
    end
    ctrl_reg = 8'h00;
    tick;
  endtask

  task automatic test_small_array;
    int n;
    // Inference on the 4x4 instance: drain is 7 cycles
    num4 = 7'd1;
    ctrl4 = 8'h01;
    tick;
    ctrl4 = 8'h00;
    tick;
    dr4 = 1'b1; data4 = 64'h1111_2222_3333_4444;
    tick;
    checks++;
    if (iv4 !== 1'b1 || ai4 !== 64'h1111_2222_3333_4444) begin
      errors++; $display("FAIL s4_send: iv=%b ai=%h", iv4, ai4);
    end
    dr4 = 1'b0;
    tick;
    n = 1;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (go4) break;
      n++;
    end
    checks++;
    if (n !== 7 || go4 !== 1'b1) begin
      errors++; $display("FAIL s4_drain_len: got %0d go=%b expected 7 1", n, go4);
    end
    tick;
    od4 = 1'b1;
    tick;
    od4 = 1'b0;
    checks++;
    if (infd4 !== 1'b1) begin errors++; $display("FAIL s4_done: got %b expected 1", infd4); end
    tick;
    // Full 4-row weight load
    ctrl4 = 8'h02;
    tick;
    ctrl4 = 8'h00;
    for (int r = 0; r < 4; r++) begin
      tick;
      dr4 = 1'b1; data4 = 64'(r);
      tick;
      checks++;
      if (load4 !== (4'b0001 << r)) begin
        errors++; $display("FAIL s4_load row %0d: load=%b expected %b", r, load4, 4'b0001 << r);
      end
      dr4 = 1'b0;
      tick;
      checks++;
      if (r < 3 ? (gw4 !== 1'b1) : (busy4 !== 1'b0)) begin
        errors++; $display("FAIL s4_step row %0d: gw=%b busy=%b", r, gw4, busy4);
      end
    end
    // Reset in the middle of a load
    ctrl4 = 8'h02;
    tick;
    ctrl4 = 8'h00;
    tick;
    dr4 = 1'b1; data4 = 64'hDEAD;
    tick;
    dr4 = 1'b0;
    checks++;
    if (load4 !== 4'b0001 || busy4 !== 1'b1) begin
      errors++; $display("FAIL s4_preload: load=%b busy=%b expected 0001 1", load4, busy4);
    end
    rst4 = 1'b1;
    tick;
    checks++;
    if ({busy4, infd4, err4, gw4, gi4, go4, iv4} !== 7'b0 || load4 !== 4'b0 || ai4 !== 64'h0) begin
      errors++; $display("FAIL s4_rst: flags=%b load=%b ai=%h expected 0", {busy4, infd4, err4, gw4, gi4, go4, iv4}, load4, ai4);
    end
    rst4 = 1'b0;
    tick; tick;
    checks++;
    if (busy4 !== 1'b0 || gw4 !== 1'b0) begin
      errors++; $display("FAIL s4_post_rst: busy=%b gw=%b expected 0 0", busy4, gw4);
    end
  endtask

  initial begin
    rst = 1'b1; ctrl_reg = '0; num_inputs = '0; timeout_cfg = '0;
    data_ready = 1'b0; out_done = 1'b0; data = '0;
    rst4 = 1'b1; ctrl4 = '0; num4 = '0; tmo4 = '0;
    dr4 = 1'b0; od4 = 1'b0; data4 = '0;
    test_reset;
    test_weight_load;
    test_inference;
    test_watchdog;
    test_abort;
    test_commands;
    test_small_array;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
